// File: rtl/pc_branch_ctrl.sv
// Program counter register with unconditional loads, a one-cycle conditional
// branch evaluation state, exception entry and saturating branch statistics.
module pc_branch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_00FF,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pc_write,
    input  logic             pc_write_cond,
    input  logic             cond_in,
    input  logic [1:0]       pc_source,
    input  logic [31:0]      alu_result,
    input  logic [31:0]      alu_out,
    input  logic [25:0]      jump_imm,
    input  logic             exc_req,
    output logic [31:0]      pc,
    output logic [31:0]      epc,
    output logic             busy,
    output logic             branch_taken,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] not_taken_cnt
);
    typedef enum logic {IDLE, EVAL} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t      state;
    logic [31:0] target_q;
    logic [31:0] src_val;

    always_comb begin
        src_val = alu_result;
        case (pc_source)
            2'b00: src_val = alu_result;
            2'b01: src_val = alu_out;
            2'b10: src_val = {pc[31:28], jump_imm, 2'b00};
            2'b11: src_val = epc;
            default: src_val = alu_result;
        endcase
    end

    assign busy = (state == EVAL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            epc           <= '0;
            target_q      <= '0;
            branch_taken  <= 1'b0;
            taken_cnt     <= '0;
            not_taken_cnt <= '0;
        end else begin
            branch_taken <= 1'b0;
            case (state)
                IDLE: begin
                    if (exc_req) begin
                        epc <= pc;
                        pc  <= EXC_VECTOR;
                    end else if (pc_write) begin
                        pc <= src_val;
                    end else if (pc_write_cond) begin
                        target_q <= src_val;
                        state    <= EVAL;
                    end
                end
                EVAL: begin
                    // cond_in has had a full cycle to settle; pc_write* are dropped here
                    state <= IDLE;
                    if (exc_req) begin
                        epc <= pc;
                        pc  <= EXC_VECTOR;
                    end else if (cond_in) begin
                        pc           <= target_q;
                        branch_taken <= 1'b1;
                        if (taken_cnt != CNT_MAX)
                            taken_cnt <= taken_cnt + 1'b1;
                    end else begin
                        if (not_taken_cnt != CNT_MAX)
                            not_taken_cnt <= not_taken_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Directed plus random bench for pc_branch_ctrl against a behavioural model.
module tb_pc_branch_ctrl;
    localparam int          CNT_W = 2;
    localparam logic [31:0] RST   = 32'h0000_0000;
    localparam logic [31:0] VEC   = 32'h0000_00FF;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset, pc_write, pc_write_cond, cond_in, exc_req;
    logic [1:0]       pc_source;
    logic [31:0]      alu_result, alu_out;
    logic [25:0]      jump_imm;
    logic [31:0]      pc, epc;
    logic             busy, branch_taken;
    logic [CNT_W-1:0] taken_cnt, not_taken_cnt;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [31:0] m_pc, m_epc, m_tgt;
    bit          m_eval, m_bt;
    int          m_tc, m_nt;

    pc_branch_ctrl #(.RESET_PC(RST), .EXC_VECTOR(VEC), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .cond_in(cond_in), .pc_source(pc_source), .alu_result(alu_result),
        .alu_out(alu_out), .jump_imm(jump_imm), .exc_req(exc_req), .pc(pc), .epc(epc),
        .busy(busy), .branch_taken(branch_taken), .taken_cnt(taken_cnt),
        .not_taken_cnt(not_taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] next_src();
        case (pc_source)
            2'd0: return alu_result;
            2'd1: return alu_out;
            2'd2: return {m_pc[31:28], jump_imm, 2'b00};
            default: return m_epc;
        endcase
    endfunction

    // One clock edge in the model, using the inputs the DUT just sampled.
    task automatic model_step();
        logic [31:0] src;
        src  = next_src();
        m_bt = 0;
        if (reset) begin
            m_pc = RST; m_epc = 0; m_tgt = 0; m_eval = 0; m_tc = 0; m_nt = 0;
        end else if (!m_eval) begin
            if (exc_req) begin m_epc = m_pc; m_pc = VEC; end
            else if (pc_write) m_pc = src;
            else if (pc_write_cond) begin m_tgt = src; m_eval = 1; end
        end else begin
            m_eval = 0;
            if (exc_req) begin m_epc = m_pc; m_pc = VEC; end
            else if (cond_in) begin
                m_pc = m_tgt; m_bt = 1;
                if (m_tc < CMAX) m_tc++;
            end else if (m_nt < CMAX) m_nt++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("pc", pc, m_pc);
        chk("epc", epc, m_epc);
        chk("busy", {31'b0, busy}, {31'b0, m_eval});
        chk("branch_taken", {31'b0, branch_taken}, {31'b0, m_bt});
        chk("taken_cnt", 32'(taken_cnt), 32'(m_tc));
        chk("not_taken_cnt", 32'(not_taken_cnt), 32'(m_nt));
    endtask

    initial begin
        reset = 1; pc_write = 0; pc_write_cond = 0; cond_in = 0; exc_req = 0;
        pc_source = 0; alu_result = 0; alu_out = 0; jump_imm = 0;
        m_pc = 0; m_epc = 0; m_tgt = 0; m_eval = 0; m_bt = 0; m_tc = 0; m_nt = 0;
        #2;
        tick(); tick();
        reset = 0;
        tick(); tick(); tick();
        chk("reset_pc", pc, RST);
        chk("reset_cnt", 32'(taken_cnt), 32'd0);

        // unconditional writes
        alu_result = 32'd4; pc_source = 2'd0; pc_write = 1; tick(); pc_write = 0;
        chk("uncond_pc4", pc, 32'd4);
        pc_source = 2'd2; jump_imm = 26'h10; pc_write = 1; tick(); pc_write = 0;
        chk("jump_pc40", pc, 32'h40);

        // taken branch from pc=8
        alu_result = 32'd8; pc_source = 2'd0; pc_write = 1; tick(); pc_write = 0;
        alu_out = 32'h100; pc_source = 2'd1; pc_write_cond = 1; tick(); pc_write_cond = 0;
        chk("taken_busy", {31'b0, busy}, 32'd1);
        chk("taken_pc_hold", pc, 32'd8);
        cond_in = 1; tick(); cond_in = 0;
        chk("taken_pc", pc, 32'h100);
        chk("taken_pulse", {31'b0, branch_taken}, 32'd1);
        chk("taken_busy_off", {31'b0, busy}, 32'd0);
        tick();
        chk("taken_pulse_off", {31'b0, branch_taken}, 32'd0);

        // not-taken branch, with pc_write during EVAL ignored
        alu_result = 32'd8; pc_source = 2'd0; pc_write = 1; tick(); pc_write = 0;
        pc_source = 2'd1; pc_write_cond = 1; tick(); pc_write_cond = 0;
        alu_result = 32'h200; pc_source = 2'd0; pc_write = 1; cond_in = 0; tick(); pc_write = 0;
        chk("nt_pc", pc, 32'd8);
        chk("nt_cnt", 32'(not_taken_cnt), 32'd1);
        chk("nt_nopulse", {31'b0, branch_taken}, 32'd0);
        tick();
        chk("nt_busy_off", {31'b0, busy}, 32'd0);

        // exception aborts EVAL, then return via epc
        pc_source = 2'd1; pc_write_cond = 1; tick(); pc_write_cond = 0;
        exc_req = 1; cond_in = 1; tick(); exc_req = 0; cond_in = 0;
        chk("exc_epc", epc, 32'd8);
        chk("exc_pc", pc, VEC);
        chk("exc_taken_cnt", 32'(taken_cnt), 32'd1);
        pc_source = 2'd3; pc_write = 1; tick(); pc_write = 0;
        chk("eret_pc", pc, 32'd8);

        // saturation
        for (int i = 0; i < 5; i++) begin
            pc_source = 2'd1; alu_out = 32'h300 + 32'(i * 4);
            pc_write_cond = 1; tick(); pc_write_cond = 0;
            cond_in = 1; tick(); cond_in = 0;
        end
        chk("sat_taken", 32'(taken_cnt), 32'd3);

        // reset mid-EVAL discards branch
        pc_write_cond = 1; tick(); pc_write_cond = 0;
        cond_in = 1; reset = 1; tick(); reset = 0; cond_in = 0;
        chk("rst_eval_pc", pc, RST);
        chk("rst_eval_pulse", {31'b0, branch_taken}, 32'd0);
        chk("rst_eval_busy", {31'b0, busy}, 32'd0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            reset         = ($urandom_range(0, 31) == 0);
            exc_req       = ($urandom_range(0, 7) == 0);
            pc_write      = ($urandom_range(0, 3) == 0);
            pc_write_cond = ($urandom_range(0, 1) == 0);
            cond_in       = $urandom_range(0, 1) == 1;
            pc_source     = 2'($urandom_range(0, 3));
            alu_result    = $urandom;
            alu_out       = $urandom;
            jump_imm      = 26'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
